// File: rtl/spi_flash_word_loader_if.sv
// spi_flash_word_loader_if: word-push channel and byte-level spi_master channel of the loader
//   wr_valid/wr_ready/wr_addr/wr_data : word push handshake
//   resync                            : forget the last address, next word sends an address phase
//   spi_start/spi_data/spi_done       : byte start pulse, byte value, completion from spi_master
//   master = word source + spi_master side, slave = the loader
interface spi_flash_word_loader_if #(
  parameter int ADDR_BYTES = 4,
  parameter int DATA_BYTES = 4
);
  logic                    wr_valid;
  logic                    wr_ready;
  logic [8*ADDR_BYTES-1:0] wr_addr;
  logic [8*DATA_BYTES-1:0] wr_data;
  logic                    resync;
  logic                    spi_start;
  logic [7:0]              spi_data;
  logic                    spi_done;
  modport master (output wr_valid, wr_addr, wr_data, resync, spi_done, input wr_ready, spi_start, spi_data);
  modport slave (input wr_valid, wr_addr, wr_data, resync, spi_done, output wr_ready, spi_start, spi_data);
endinterface

// File: rtl/spi_flash_word_loader.sv
// spi_flash_word_loader: turns (address, data) words into CMD_ADDR+address / CMD_DATA+data SPI byte sequences
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   bus            : word push handshake, resync, and spi_master start/data/done
//   o_busy         : FIFO non-empty or sequencer active
//   o_words_sent   : completed words, wraps mod 2^16
module spi_flash_word_loader #(
  parameter int         ADDR_BYTES = 4,
  parameter int         DATA_BYTES = 4,
  parameter int         FIFO_DEPTH = 8,
  parameter bit         BURST_MODE = 1'b0,
  parameter int         GAP_CYCLES = 1,
  parameter logic [7:0] CMD_ADDR   = 8'h01,
  parameter logic [7:0] CMD_DATA   = 8'h02
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  spi_flash_word_loader_if.slave bus,
  output logic                  o_busy,
  output logic [15:0]           o_words_sent
);
  localparam int AW = 8 * ADDR_BYTES;
  localparam int DW = 8 * DATA_BYTES;
  localparam int NB = 2 + ADDR_BYTES + DATA_BYTES;
  localparam int IW = $clog2(NB + 1);
  localparam int PW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);
  localparam logic [IW-1:0] END_IDX  = IW'(NB);
  localparam logic [IW-1:0] DATA_IDX = IW'(ADDR_BYTES + 1);
  localparam logic [3:0]    GAP_END  = 4'(GAP_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, POP, ISSUE, WAIT, GAP} state_t;
  state_t state, state_d;
  logic [AW+DW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [AW-1:0] cur_addr, last_addr, head_addr;
  logic [DW-1:0] cur_data, head_data;
  logic [IW-1:0] idx;
  logic [3:0] gap_cnt;
  logic [7:0] data_q, plan_byte;
  logic [8*NB-1:0] plan_sh;
  logic have_last, done_q, rise, empty, push, pop, skip, fin;
  // pointers carry one extra wrap bit so full and empty differ
  assign empty = wr_ptr == rd_ptr;
  assign bus.wr_ready = (wr_ptr - rd_ptr) != PW'(FIFO_DEPTH);
  assign push = bus.wr_valid && bus.wr_ready;
  assign pop = state == POP;
  assign {head_addr, head_data} = mem[rd_ptr[PW-2:0]];
  // contiguity uses the address-width wraparound sum
  assign skip = BURST_MODE && have_last && !bus.resync && head_addr == last_addr + AW'(DATA_BYTES);
  assign rise = bus.spi_done && !done_q;
  // idx indexes the full plan; a burst word simply starts at the data command
  assign plan_sh = {CMD_ADDR, cur_addr, CMD_DATA, cur_data} << {idx, 3'b000};
  assign plan_byte = plan_sh[8*NB-1 -: 8];
  assign fin = state == WAIT && rise && idx == LAST_IDX;
  assign bus.spi_start = state == ISSUE;
  assign bus.spi_data = state == ISSUE ? plan_byte : data_q;
  assign o_busy = !empty || state != IDLE;
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = empty ? IDLE : POP;
      POP:     state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (rise) state_d = GAP_CYCLES != 0 ? GAP : fin ? IDLE : ISSUE;
      GAP:     if (gap_cnt == GAP_END) state_d = idx == END_IDX ? IDLE : ISSUE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge i_clk)
    if (push) mem[wr_ptr[PW-2:0]] <= {bus.wr_addr, bus.wr_data};
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cur_addr <= '0;
      cur_data <= '0;
      last_addr <= '0;
      have_last <= 1'b0;
      idx <= '0;
      gap_cnt <= '0;
      data_q <= '0;
      done_q <= 1'b0;
      o_words_sent <= '0;
    end else begin
      done_q <= bus.spi_done;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        cur_addr <= head_addr;
        cur_data <= head_data;
        idx <= skip ? DATA_IDX : '0;
      end
      if (state == WAIT && rise) idx <= idx + 1'b1;
      if (fin) begin
        last_addr <= cur_addr;
        o_words_sent <= o_words_sent + 1'b1;
      end
      have_last <= !bus.resync && (fin || have_last);
      gap_cnt <= state == GAP && gap_cnt != GAP_END ? gap_cnt + 1'b1 : '0;
      data_q <= state_d == IDLE ? '0 : bus.spi_start ? plan_byte : data_q;
    end
endmodule

// File: tb/tb_spi_flash_word_loader.sv
// tb_spi_flash_word_loader: directed vectors for a default loader (u_a) and a burst loader with a 3-cycle gap (u_b)
module tb_spi_flash_word_loader;
  typedef struct {
    bit          b;
    bit          rs;
    logic [31:0] a;
    logic [31:0] d;
    int          n;
    logic [79:0] seq;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  spi_flash_word_loader_if #(.ADDR_BYTES(4), .DATA_BYTES(4)) ifa ();
  spi_flash_word_loader_if #(.ADDR_BYTES(4), .DATA_BYTES(4)) ifb ();
  logic [15:0] words_a, words_b;
  logic busy_a, busy_b;
  logic [31:0] wr_addr = '0, wr_data = '0;
  logic valid_a = 1'b0, valid_b = 1'b0, resync_b = 1'b0, stall_a = 1'b0;
  int cnt_a, cnt_b;
  int checks = 0, errors = 0, gap_checks = 0, exp_a = 0, exp_b = 0;
  logic [7:0] cap_a [$];
  logic [7:0] cap_b [$];
  assign ifa.wr_addr = wr_addr;
  assign ifa.wr_data = wr_data;
  assign ifa.wr_valid = valid_a;
  assign ifa.resync = 1'b0;
  assign ifb.wr_addr = wr_addr;
  assign ifb.wr_data = wr_data;
  assign ifb.wr_valid = valid_b;
  assign ifb.resync = resync_b;
  // spi_master models: A answers 1 cycle late for 1 cycle, B 2 cycles late held for 3 cycles
  assign ifa.spi_done = !stall_a && cnt_a != 0 && cnt_a <= 1;
  assign ifb.spi_done = cnt_b != 0 && cnt_b <= 3;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_a <= 0;
    else if (ifa.spi_start) cnt_a <= 2;
    else if (cnt_a != 0 && !stall_a) cnt_a <= cnt_a - 1;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_b <= 0;
    else if (ifb.spi_start) cnt_b <= 5;
    else if (cnt_b != 0) cnt_b <= cnt_b - 1;
  spi_flash_word_loader u_a (
    .i_clk(clk), .i_rst_n(rst_n), .bus(ifa), .o_busy(busy_a), .o_words_sent(words_a)
  );
  spi_flash_word_loader #(.BURST_MODE(1'b1), .GAP_CYCLES(3)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .bus(ifb), .o_busy(busy_b), .o_words_sent(words_b)
  );
  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  logic sa_prev = 1'b0;
  always @(posedge clk) begin
    if (ifa.spi_start) begin
      cap_a.push_back(ifa.spi_data);
      checks++;
      if (sa_prev) begin
        errors++;
        $display("FAIL start_a_single_cycle: got back-to-back starts expected one-cycle pulse");
      end
    end
    sa_prev = ifa.spi_start;
  end
  // B monitor: bytes, one-cycle start pulses, and done-edge-to-start spacing inside a word
  logic sb_prev = 1'b0, db_prev = 1'b0;
  logic [15:0] wb_prev = '0;
  int cyc_b = 0, t_done = -1;
  always @(posedge clk) begin
    cyc_b++;
    if (!rst_n) begin
      t_done = -1;
      db_prev = 1'b0;
    end else begin
      if (words_b != wb_prev) t_done = -1;
      if (ifb.spi_done && !db_prev) t_done = cyc_b;
      if (ifb.spi_start) begin
        cap_b.push_back(ifb.spi_data);
        checks++;
        if (sb_prev) begin
          errors++;
          $display("FAIL start_b_single_cycle: got back-to-back starts expected one-cycle pulse");
        end
        if (t_done >= 0) begin
          checks++;
          gap_checks++;
          if (cyc_b - t_done != 4) begin
            errors++;
            $display("FAIL gap_b: got %0d cycles expected 4", cyc_b - t_done);
          end
          t_done = -1;
        end
      end
      db_prev = ifb.spi_done;
    end
    wb_prev = words_b;
    sb_prev = ifb.spi_start;
  end
  task automatic push(input bit b, input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    @(negedge clk);
    wr_addr = a;
    wr_data = d;
    valid_a = !b;
    valid_b = b;
    while (!(b ? ifb.wr_ready : ifa.wr_ready) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: got no wr_ready expected ready within 1000 cycles");
    end
    @(negedge clk);
    valid_a = 1'b0;
    valid_b = 1'b0;
  endtask
  task automatic run_vec(input vec_t v, input int k);
    int n = 0;
    logic [79:0] got = '0;
    if (v.b) cap_b.delete();
    else cap_a.delete();
    if (v.rs) begin
      @(negedge clk);
      resync_b = 1'b1;
      @(negedge clk);
      resync_b = 1'b0;
    end
    push(v.b, v.a, v.d);
    while (!(v.b ? ifb.spi_start : ifa.spi_start) && n < 10) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("v%0d_latency", k), n + 1, 3);
    n = 0;
    while ((v.b ? busy_b : busy_a) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("v%0d_busy_fell", k), n < 400, 1);
    if (v.b) exp_b++;
    else exp_a++;
    for (int i = 0; i < 10; i++)
      if (i < (v.b ? cap_b.size() : cap_a.size())) got[79-8*i -: 8] = v.b ? cap_b[i] : cap_a[i];
    check($sformatf("v%0d_nbytes", k), v.b ? cap_b.size() : cap_a.size(), v.n);
    check($sformatf("v%0d_bytes", k), got, v.seq);
    check($sformatf("v%0d_words_sent", k), v.b ? words_b : words_a, v.b ? exp_b : exp_a);
    check($sformatf("v%0d_data_idle", k), v.b ? ifb.spi_data : ifa.spi_data, 0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before 500us");
    $fatal(1);
  end
  initial begin
    vec_t tbl [10];
    int n;
    logic [79:0] got;
    tbl[0] = '{1'b0, 1'b0, 32'h1000_0000, 32'hDEAD_BEEF, 10, 80'h01_10000000_02_DEADBEEF};
    tbl[1] = '{1'b0, 1'b0, 32'h0000_0004, 32'h1234_5678, 10, 80'h01_00000004_02_12345678};
    tbl[2] = '{1'b1, 1'b0, 32'h1000_0000, 32'hCAFE_F00D, 10, 80'h01_10000000_02_CAFEF00D};
    tbl[3] = '{1'b1, 1'b0, 32'h1000_0004, 32'h0102_0304, 5, 80'h0201020304_0000000000};
    tbl[4] = '{1'b1, 1'b0, 32'h2000_0000, 32'hA5A5_5A5A, 10, 80'h01_20000000_02_A5A55A5A};
    tbl[5] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h1111_2222, 10, 80'h01_FFFFFFFC_02_11112222};
    tbl[6] = '{1'b1, 1'b0, 32'h0000_0000, 32'h3333_4444, 5, 80'h0233334444_0000000000};
    tbl[7] = '{1'b1, 1'b1, 32'h0000_0004, 32'h5566_7788, 10, 80'h01_00000004_02_55667788};
    tbl[8] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h9999_AAAA, 10, 80'h01_FFFFFFFC_02_9999AAAA};
    tbl[9] = '{1'b1, 1'b1, 32'h0000_0000, 32'hBBBB_CCCC, 10, 80'h01_00000000_02_BBBBCCCC};
    repeat (3) @(negedge clk);
    check("rst_ready_a", ifa.wr_ready, 1);
    check("rst_busy_a", busy_a, 0);
    check("rst_words_a", words_a, 0);
    check("rst_start_a", ifa.spi_start, 0);
    check("rst_data_a", ifa.spi_data, 0);
    check("rst_words_b", words_b, 0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 10; k++) run_vec(tbl[k], k);
    // FIFO fill: word 0 stalls on its first byte, words 1-8 fill the FIFO, word 9 waits for a pop
    cap_a.delete();
    stall_a = 1'b1;
    push(1'b0, 32'h0000_0100, 32'hA000_0000);
    n = 0;
    while (cap_a.size() == 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 1; i <= 8; i++) push(1'b0, 32'h0000_0100 + 4 * i, 32'hA000_0000 + i);
    check("fifo_full_ready", ifa.wr_ready, 0);
    fork
      push(1'b0, 32'h0000_0124, 32'hA000_0009);
      begin
        repeat (4) @(negedge clk);
        check("fifo_push_held", ifa.wr_ready, 0);
        check("fifo_stalled_bytes", cap_a.size(), 1);
        stall_a = 1'b0;
      end
    join
    n = 0;
    while (busy_a && n < 3000) begin
      @(negedge clk);
      n++;
    end
    exp_a += 10;
    check("fifo_busy_fell", n < 3000, 1);
    check("fifo_words_sent", words_a, exp_a);
    check("fifo_nbytes", cap_a.size(), 100);
    for (int w = 0; w < 10; w++) begin
      got = '0;
      for (int i = 0; i < 10; i++) if (10 * w + i < cap_a.size()) got[79-8*i -: 8] = cap_a[10*w+i];
      check($sformatf("fifo_word%0d", w), got, {8'h01, 32'h0000_0100 + 4 * w, 8'h02, 32'hA000_0000 + w});
    end
    check("gap_checks_ran", gap_checks >= 30, 1);
    // reset while u_b is waiting on the third address byte
    cap_b.delete();
    push(1'b1, 32'h4012_3456, 32'h0F0F_0F0F);
    n = 0;
    while (cap_b.size() < 4 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("pre_rst_nbytes", cap_b.size(), 4);
    check("pre_rst_data", ifb.spi_data, 8'h34);
    check("pre_rst_words", words_b, exp_b);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_start", ifb.spi_start, 0);
    check("async_rst_data", ifb.spi_data, 0);
    check("async_rst_words_b", words_b, 0);
    check("async_rst_busy", busy_b, 0);
    check("async_rst_ready", ifb.wr_ready, 1);
    check("async_rst_words_a", words_a, 0);
    exp_a = 0;
    exp_b = 0;
    repeat (3) @(negedge clk);
    check("rst_no_starts", cap_b.size(), 4);
    rst_n = 1'b1;
    run_vec('{1'b1, 1'b0, 32'h0000_0004, 32'h1357_9BDF, 10, 80'h01_00000004_02_13579BDF}, 10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
